// File: rtl/fp16_acc_feeder.sv
// fp16_acc_feeder: buffers one fp16 vector, streams it into an external
// accumulator, captures the accumulator's sum and holds it for downstream.
// No arithmetic happens here; words pass through bit-exact.
module fp16_acc_feeder #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_data,
    input  logic                     in_last,
    output logic [15:0]              acc_a,
    output logic                     acc_done,
    input  logic [15:0]              acc_sum,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [15:0]              res_data,
    output logic [$clog2(DEPTH):0]   res_count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {LOAD, STREAM, CAPTURE, HOLD} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   wr_cnt, rd_ptr;
    logic [15:0]     buf_mem [DEPTH];
    logic            accept;
    logic            stream_last;

    // The element under rd_ptr is the final one of the buffered vector.
    assign stream_last = (rd_ptr == wr_cnt - CW'(1));

    // Next-state and Moore outputs; idle states keep the accumulator cleared
    // by holding acc_done high with a zero operand.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        acc_done  = 1'b1;
        acc_a     = 16'h0000;
        busy      = 1'b1;
        res_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                accept   = in_valid;
                // Explicit last, or the buffer just filled (forced last).
                if (in_valid && (in_last || wr_cnt == CW'(DEPTH - 1)))
                    state_nx = STREAM;
            end
            STREAM: begin
                acc_a    = buf_mem[rd_ptr[AW-1:0]];
                acc_done = stream_last;
                if (stream_last)
                    state_nx = CAPTURE;
            end
            CAPTURE: begin
                state_nx = HOLD;
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nx;
    end

    // Write count and read pointer; both rewind when the result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_ptr <= '0;
        end else begin
            case (state)
                LOAD:    if (accept) wr_cnt <= wr_cnt + CW'(1);
                STREAM:  rd_ptr <= rd_ptr + CW'(1);
                HOLD:    if (res_ready) begin
                             wr_cnt <= '0;
                             rd_ptr <= '0;
                         end
                default: ;
            endcase
        end
    end

    // Vector buffer; contents after reset are don't-care, so no reset here.
    always_ff @(posedge clk) begin
        if (accept)
            buf_mem[wr_cnt[AW-1:0]] <= in_data;
    end

    // Result capture: the accumulator output is final in the CAPTURE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data  <= 16'h0000;
            res_count <= '0;
        end else if (state == CAPTURE) begin
            res_data  <= acc_sum;
            res_count <= wr_cnt;
        end
    end

endmodule

// File: tb/tb_fp16_acc_feeder.sv
// Directed bench for fp16_acc_feeder with a small behavioural fp16
// accumulator (exact for small non-negative integers) attached.
module tb_fp16_acc_feeder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic [15:0] acc_a;
    logic        acc_done;
    logic [15:0] acc_sum;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [$clog2(DEPTH):0] res_count;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    fp16_acc_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .acc_a(acc_a), .acc_done(acc_done), .acc_sum(acc_sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_count(res_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // fp16 <-> int for small non-negative integers
    function automatic int f2i(input logic [15:0] h);
        int e, m;
        e = int'(h[14:10]);
        if (e == 0) return 0;
        m = 1024 + int'(h[9:0]);
        if (e >= 25) return m <<< (e - 25);
        return m >>> (25 - e);
    endfunction

    function automatic logic [15:0] i2f(input int v);
        int p, mant;
        if (v <= 0) return 16'h0000;
        p = 0;
        for (int i = 0; i < 31; i++) if ((v >> i) != 0) p = i;
        mant = (v << (10 - p)) & 1023;
        return {1'b0, 5'(p + 15), 10'(mant)};
    endfunction

    // Accumulator stub: a sample taken with acc_done=1 is the last of a
    // sum; the following sample restarts from zero.
    logic [15:0] sum_r = 16'h0000;
    logic        clr_r = 1'b1;
    assign acc_sum = sum_r;
    always_ff @(posedge clk) begin
        sum_r <= i2f((clr_r ? 0 : f2i(sum_r)) + f2i(acc_a));
        clr_r <= acc_done;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=stuck expected=finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        in_valid = 1'b1; in_data = d; in_last = l;
        tick();
        in_valid = 1'b0; in_last = 1'b0; in_data = 16'hDEAD;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; res_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_acc_done", acc_done, 1);
        chk("rst_acc_a", acc_a, 16'h0000);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 16'h0000);
        chk("rst_res_count", res_count, 0);

        // two-element vector 1.0 + 2.0 = 3.0
        send(16'h3C00, 1'b0);
        chk("v2_busy_load", busy, 0);
        send(16'h4000, 1'b1);
        chk("v2_s1_a", acc_a, 16'h3C00);
        chk("v2_s1_done", acc_done, 0);
        chk("v2_s1_in_ready", in_ready, 0);
        chk("v2_s1_busy", busy, 1);
        tick();
        chk("v2_s2_a", acc_a, 16'h4000);
        chk("v2_s2_done", acc_done, 1);
        tick();
        chk("v2_cap_done", acc_done, 1);
        chk("v2_cap_a", acc_a, 16'h0000);
        chk("v2_cap_res_valid", res_valid, 0);
        tick();
        chk("v2_hold_valid", res_valid, 1);
        chk("v2_hold_data", res_data, 16'h4200);
        chk("v2_hold_count", res_count, 2);
        // hold stable while downstream stalls
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, 16'h4200);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_acc_done", acc_done, 1);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_res_valid", res_valid, 0);
        chk("rel_busy", busy, 0);

        // in_last without in_valid is ignored
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        chk("stray_last_busy", busy, 0);

        // single element; res_ready held high throughout (ignored until HOLD)
        res_ready = 1'b1;
        send(16'h4200, 1'b1);
        chk("v1_a", acc_a, 16'h4200);
        chk("v1_done", acc_done, 1);
        tick();
        chk("v1_cap_busy", busy, 1);
        chk("v1_cap_valid", res_valid, 0);
        tick();
        chk("v1_hold_valid", res_valid, 1);
        chk("v1_hold_data", res_data, 16'h4200);
        chk("v1_hold_count", res_count, 1);
        tick();
        res_ready = 1'b0;
        chk("v1_rel_in_ready", in_ready, 1);
        chk("v1_rel_valid", res_valid, 0);

        // full buffer, in_last never set: forced last on word 16
        for (int i = 0; i < DEPTH; i++) send(16'h3C00, 1'b0);
        chk("full_in_ready", in_ready, 0);
        chk("full_s1_a", acc_a, 16'h3C00);
        chk("full_s1_done", acc_done, 0);
        for (int i = 1; i < DEPTH; i++) tick();
        chk("full_last_done", acc_done, 1);
        tick(); tick();
        chk("full_hold_valid", res_valid, 1);
        chk("full_hold_count", res_count, 16);
        chk("full_hold_data", res_data, 16'h4C00);
        res_ready = 1'b1; tick(); res_ready = 1'b0;

        // reset on the second STREAM cycle discards the vector
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        send(16'h4200, 1'b1);
        tick();
        chk("mid_s2_a", acc_a, 16'h4000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_done", acc_done, 1);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_count", res_count, 0);
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b1);
        chk("post_rst_s1_a", acc_a, 16'h3C00);
        tick(); tick(); tick();
        chk("post_rst_valid", res_valid, 1);
        chk("post_rst_data", res_data, 16'h4200);
        chk("post_rst_count", res_count, 2);
        res_ready = 1'b1; tick(); res_ready = 1'b0;

        // gaps of 1..3 idle cycles between words; junk on idle cycles
        in_data = 16'hFFFF; tick();
        send(16'h3C00, 1'b0);
        in_data = 16'hFFFF; in_last = 1'b1; tick(); tick(); in_last = 1'b0;
        send(16'h4000, 1'b0);
        in_data = 16'hFFFF; tick(); tick(); tick();
        send(16'h4200, 1'b1);
        chk("gap_a0", acc_a, 16'h3C00);
        chk("gap_d0", acc_done, 0);
        tick();
        chk("gap_a1", acc_a, 16'h4000);
        chk("gap_d1", acc_done, 0);
        tick();
        chk("gap_a2", acc_a, 16'h4200);
        chk("gap_d2", acc_done, 1);
        tick(); tick();
        chk("gap_valid", res_valid, 1);
        chk("gap_data", res_data, 16'h4600);
        chk("gap_count", res_count, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
